// File: rtl/square_pkg.sv
// Shared helpers for the square field: growth-rate curve, staggered reset depths
// and the LFSR rotation used to decorrelate per-square respawn offsets.
package square_pkg;

  localparam int unsigned RndW      = 8;
  localparam int unsigned PassedW   = 8;
  localparam int unsigned PassedMax = 255;

  // Step size in fraction units: 2.0, 1.0, 0.5, 0.25 for the four depth bands.
  function automatic int unsigned growth_rate(input int unsigned k, input int unsigned depth_i,
                                              input int unsigned frac);
    int unsigned band;
    band = (k >> (depth_i - 2)) & 32'd3;
    return (32'd1 << (frac + 1)) >> band;
  endfunction

  // Integer depth of square idx at reset; wraps modulo 2^depth_i.
  function automatic int unsigned reset_depth(input int unsigned idx, input int unsigned depth_i,
                                              input int unsigned spacing);
    int unsigned dmax;
    dmax = (32'd1 << depth_i) - 32'd1;
    return (dmax - idx * spacing) & dmax;
  endfunction

  function automatic logic [RndW-1:0] rotl_rnd(input logic [RndW-1:0] v, input int unsigned n);
    logic [2*RndW-1:0] w;
    w = {v, v} << (n % RndW);
    return w[2*RndW-1 -: RndW];
  endfunction

endpackage

// File: rtl/square_chan.sv
// One obstacle square: fixed-point depth/position state, per-frame advance,
// joystick drift, respawn at the far plane and the cruiser proximity compare.
module square_chan
  import square_pkg::*;
#(
  parameter int unsigned POS_I       = 7,
  parameter int unsigned DEPTH_I     = 6,
  parameter int unsigned FRAC        = 7,
  parameter int unsigned SPACING     = 16,
  parameter int unsigned HIT_R       = 4,
  parameter bit          RESPAWN_ABS = 1'b0,
  parameter int unsigned INDEX       = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               step_i,
  input  logic               clear_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic               left_i,
  input  logic               right_i,
  input  logic [POS_I-1:0]   cruiser_x_i,
  input  logic [POS_I-1:0]   cruiser_y_i,
  input  logic [RndW-1:0]    rnd_i,
  output logic [POS_I-1:0]   x_o,
  output logic [POS_I-1:0]   y_o,
  output logic [DEPTH_I-1:0] depth_o,
  output logic               respawn_o,
  output logic               hit_o
);

  localparam int unsigned DW = DEPTH_I + FRAC;
  localparam int unsigned PW = POS_I + FRAC;
  localparam logic [DEPTH_I-1:0] DMax     = '1;
  localparam logic [DW-1:0]      DInit    = DW'(reset_depth(INDEX, DEPTH_I, SPACING)) << FRAC;
  localparam logic [DW-1:0]      DRespawn = {DMax, {FRAC{1'b0}}};
  localparam logic [PW-1:0]      PInit    = PW'((32'd1 << (POS_I - 1)) - 32'd1) << FRAC;

  logic [DW-1:0]      d_q, d_d;
  logic [PW-1:0]      x_q, x_d, y_q, y_d;
  logic [DEPTH_I-1:0] d_int;
  logic [POS_I-1:0]   x_int, y_int;
  logic [DW-1:0]      grate;
  logic [PW-1:0]      lrate, rnd_x, rnd_y;
  int unsigned        adx, ady;

  // dec has priority over inc; no move once the integer part sits at its limit.
  function automatic logic [PW-1:0] lat_move(input logic [PW-1:0] v, input logic dec,
                                             input logic inc, input logic [PW-1:0] rate);
    logic [PW:0] sum;
    lat_move = v;
    sum = {1'b0, v} + {1'b0, rate};
    if (dec) begin
      if (v[PW-1 -: POS_I] != '0) lat_move = (v < rate) ? '0 : v - rate;
    end else if (inc) begin
      if (v[PW-1 -: POS_I] != '1) lat_move = sum[PW] ? '1 : sum[PW-1:0];
    end
  endfunction

  assign d_int = d_q[DW-1 -: DEPTH_I];
  assign x_int = x_q[PW-1 -: POS_I];
  assign y_int = y_q[PW-1 -: POS_I];
  assign grate = DW'(growth_rate(32'(d_int), DEPTH_I, FRAC));
  assign lrate = PW'(growth_rate(32'(DMax - d_int), DEPTH_I, FRAC));
  assign rnd_x = PW'(rnd_i[3:0]) << FRAC;
  assign rnd_y = PW'(rnd_i[7:4]) << FRAC;

  assign respawn_o = step_i & (d_q < grate);

  // Proximity uses the pre-respawn position.
  always_comb begin
    adx = (x_int >= cruiser_x_i) ? 32'(x_int - cruiser_x_i) : 32'(cruiser_x_i - x_int);
    ady = (y_int >= cruiser_y_i) ? 32'(y_int - cruiser_y_i) : 32'(cruiser_y_i - y_int);
    hit_o = respawn_o && (adx <= HIT_R) && (ady <= HIT_R);
  end

  always_comb begin
    d_d = d_q;
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      d_d = DInit;
      x_d = PInit;
      y_d = PInit;
    end else if (respawn_o) begin
      d_d = DRespawn;
      if (RESPAWN_ABS) begin
        x_d = rnd_x;
        y_d = rnd_y;
      end else begin
        x_d = x_q + rnd_x;
        y_d = y_q + rnd_y;
      end
    end else if (step_i) begin
      d_d = d_q - grate;
      x_d = lat_move(x_q, right_i, left_i, lrate);
      y_d = lat_move(y_q, down_i, up_i, lrate);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= DInit;
      x_q <= PInit;
      y_q <= PInit;
    end else begin
      d_q <= d_d;
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o     = x_int;
  assign y_o     = y_int;
  assign depth_o = d_int;

endmodule

// File: rtl/square_field.sv
// N_SQ independent obstacle squares advancing toward the viewer, with registered
// respawn/hit pulses and a saturating count of passed squares.
module square_field
  import square_pkg::*;
#(
  parameter int unsigned N_SQ        = 4,
  parameter int unsigned POS_I       = 7,
  parameter int unsigned DEPTH_I     = 6,
  parameter int unsigned FRAC        = 7,
  parameter int unsigned SPACING     = 16,
  parameter int unsigned HIT_R       = 4,
  parameter bit          RESPAWN_ABS = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic                    up_i,
  input  logic                    down_i,
  input  logic                    left_i,
  input  logic                    right_i,
  input  logic [POS_I-1:0]        cruiser_x_i,
  input  logic [POS_I-1:0]        cruiser_y_i,
  input  logic [RndW-1:0]         random_i,
  output logic [N_SQ*POS_I-1:0]   xcenter_o,
  output logic [N_SQ*POS_I-1:0]   ycenter_o,
  output logic [N_SQ*DEPTH_I-1:0] depth_o,
  output logic [N_SQ-1:0]         respawn_o,
  output logic                    hit_o,
  output logic [PassedW-1:0]      passed_o
);

  logic                 step;
  logic [N_SQ-1:0]      resp_now, hit_now;
  logic [N_SQ-1:0]      respawn_q;
  logic                 hit_q;
  logic [PassedW-1:0]   passed_q, passed_d;
  logic [3:0]           resp_cnt;
  logic [PassedW:0]     pass_sum;

  // clear wins over enable, so a clearing cycle never produces pulses.
  assign step = enable_i & ~clear_i;

  for (genvar i = 0; i < N_SQ; i++) begin : g_sq
    logic [RndW-1:0] rnd;
    assign rnd = rotl_rnd(random_i, 2 * i);

    square_chan #(
      .POS_I      (POS_I),
      .DEPTH_I    (DEPTH_I),
      .FRAC       (FRAC),
      .SPACING    (SPACING),
      .HIT_R      (HIT_R),
      .RESPAWN_ABS(RESPAWN_ABS),
      .INDEX      (i)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .step_i     (step),
      .clear_i    (clear_i),
      .up_i       (up_i),
      .down_i     (down_i),
      .left_i     (left_i),
      .right_i    (right_i),
      .cruiser_x_i(cruiser_x_i),
      .cruiser_y_i(cruiser_y_i),
      .rnd_i      (rnd),
      .x_o        (xcenter_o[i*POS_I +: POS_I]),
      .y_o        (ycenter_o[i*POS_I +: POS_I]),
      .depth_o    (depth_o[i*DEPTH_I +: DEPTH_I]),
      .respawn_o  (resp_now[i]),
      .hit_o      (hit_now[i])
    );
  end

  always_comb begin
    resp_cnt = '0;
    for (int i = 0; i < N_SQ; i++) begin
      resp_cnt = resp_cnt + 4'(resp_now[i]);
    end
    pass_sum = {1'b0, passed_q} + (PassedW + 1)'(resp_cnt);
    passed_d = (pass_sum > (PassedW + 1)'(PassedMax)) ? PassedW'(PassedMax)
                                                      : pass_sum[PassedW-1:0];
    if (clear_i) passed_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      respawn_q <= '0;
      hit_q     <= 1'b0;
      passed_q  <= '0;
    end else begin
      respawn_q <= resp_now;
      hit_q     <= |hit_now;
      passed_q  <= passed_d;
    end
  end

  assign respawn_o = respawn_q;
  assign hit_o     = hit_q;
  assign passed_o  = passed_q;

endmodule

// File: tb/tb_square_field.sv
// Directed bench for square_field: vector table for the early frames, then
// hand sequences for drift clamping, respawn offsets, hit radius and saturation.
module tb_square_field;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, clr, up, down, left, right;
  logic [6:0] cx, cy;
  logic [7:0] rnd;

  logic [27:0] xc, yc, xa, ya;
  logic [23:0] dep, da;
  logic [3:0]  resp, ra;
  logic        hit, ha;
  logic [7:0]  passed, pa;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  square_field #(.RESPAWN_ABS(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr),
    .up_i(up), .down_i(down), .left_i(left), .right_i(right),
    .cruiser_x_i(cx), .cruiser_y_i(cy), .random_i(rnd),
    .xcenter_o(xc), .ycenter_o(yc), .depth_o(dep),
    .respawn_o(resp), .hit_o(hit), .passed_o(passed)
  );

  square_field #(.RESPAWN_ABS(1'b1)) dut_abs (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr),
    .up_i(up), .down_i(down), .left_i(left), .right_i(right),
    .cruiser_x_i(cx), .cruiser_y_i(cy), .random_i(rnd),
    .xcenter_o(xa), .ycenter_o(ya), .depth_o(da),
    .respawn_o(ra), .hit_o(ha), .passed_o(pa)
  );

  typedef struct {
    logic        en;
    logic [23:0] dep;
    logic [3:0]  resp;
    logic [7:0]  pass;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [6:0] p7(input logic [27:0] v, input int i);
    return v[i*7 +: 7];
  endfunction

  function automatic logic [5:0] p6(input logic [23:0] v, input int i);
    return v[i*6 +: 6];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 0; clr = 0; up = 0; down = 0; left = 0; right = 0;
    rnd = 8'h00; cx = 7'd0; cy = 7'd0;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    step();
  endtask

  task automatic chk_init(input string tag);
    chk({tag, "_depth"}, dep, {6'd15, 6'd31, 6'd47, 6'd63});
    chk({tag, "_x"}, xc, {4{7'd63}});
    chk({tag, "_y"}, yc, {4{7'd63}});
    chk({tag, "_passed"}, passed, 0);
    chk({tag, "_respawn"}, resp, 0);
    chk({tag, "_hit"}, hit, 0);
  endtask

  initial begin
    logic found;
    int   total;
    int   exp_pass;

    vt[0] = '{1'b1, {6'd13, 6'd30, 6'd46, 6'd62}, 4'b0000, 8'd0};
    vt[1] = '{1'b1, {6'd11, 6'd29, 6'd46, 6'd62}, 4'b0000, 8'd0};
    vt[2] = '{1'b1, {6'd9,  6'd28, 6'd45, 6'd62}, 4'b0000, 8'd0};
    vt[3] = '{1'b0, {6'd9,  6'd28, 6'd45, 6'd62}, 4'b0000, 8'd0};
    vt[4] = '{1'b1, {6'd7,  6'd27, 6'd45, 6'd62}, 4'b0000, 8'd0};
    vt[5] = '{1'b1, {6'd5,  6'd26, 6'd44, 6'd61}, 4'b0000, 8'd0};
    vt[6] = '{1'b1, {6'd3,  6'd25, 6'd44, 6'd61}, 4'b0000, 8'd0};
    vt[7] = '{1'b1, {6'd1,  6'd24, 6'd43, 6'd61}, 4'b0000, 8'd0};
    vt[8] = '{1'b1, {6'd63, 6'd23, 6'd43, 6'd61}, 4'b1000, 8'd1};
    vt[9] = '{1'b1, {6'd62, 6'd22, 6'd42, 6'd60}, 4'b0000, 8'd1};

    // Reset state and free-running advance
    do_reset();
    chk_init("reset");
    for (int i = 0; i < 10; i++) begin
      en = vt[i].en;
      step();
      chk($sformatf("vec%0d_depth", i), dep, vt[i].dep);
      chk($sformatf("vec%0d_respawn", i), resp, vt[i].resp);
      chk($sformatf("vec%0d_passed", i), passed, vt[i].pass);
      chk($sformatf("vec%0d_hit", i), hit, 0);
    end
    chk("vec_x_static", xc, {4{7'd63}});

    // Drift: right+up, then conflicting directions, then clamp at 0
    do_reset();
    en = 1; right = 1; up = 1;
    step();
    chk("a_x_step1", xc, {7'd62, 7'd62, 7'd62, 7'd61});
    chk("a_y_step1", yc, {7'd63, 7'd63, 7'd64, 7'd65});
    left = 1; down = 1;
    step();
    chk("a_x0_right_wins", p7(xc, 0), 59);
    chk("a_y0_down_wins", p7(yc, 0), 63);
    left = 0; up = 0; down = 0;
    repeat (29) step();
    chk("a_x0_near_zero", p7(xc, 0), 1);
    step();
    chk("a_x0_clamp", p7(xc, 0), 0);
    step();
    chk("a_x0_hold_zero", p7(xc, 0), 0);
    chk("a_y0_unmoved", p7(yc, 0), 63);

    // Respawn offsets, relative and absolute
    do_reset();
    en = 1; left = 1;
    repeat (31) step();
    chk("b_x0_pre", p7(xc, 0), 125);
    chk("b_x0_pre_abs", p7(xa, 0), 125);
    left = 0; rnd = 8'hA5;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      step();
      if (resp[0]) found = 1'b1;
    end
    chk("b_respawn_seen", found, 1);
    chk("b_depth0", p6(dep, 0), 63);
    chk("b_x0_wrap", p7(xc, 0), 2);
    chk("b_y0", p7(yc, 0), 73);
    chk("b_abs_respawn", ra[0], 1);
    chk("b_abs_x0", p7(xa, 0), 5);
    chk("b_abs_y0", p7(ya, 0), 10);

    // Hit radius: square 3 placed at (66,66) by its first respawn
    do_reset();
    cx = 7'd70; cy = 7'd70; rnd = 8'hCC; en = 1;
    repeat (8) step();
    chk("c_respawn3", resp, 4'b1000);
    chk("c_x3", p7(xc, 3), 66);
    chk("c_y3", p7(yc, 3), 66);
    chk("c_depth3", p6(dep, 3), 63);
    chk("c_no_hit_far", hit, 0);
    rnd = 8'h00;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      step();
      if (resp[3]) found = 1'b1;
    end
    chk("c_respawn3_again", found, 1);
    chk("c_hit_at_radius", hit, 1);
    step();
    chk("c_hit_one_cycle", hit, 0);
    cx = 7'd71;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      step();
      if (resp[3]) found = 1'b1;
    end
    chk("c_respawn3_third", found, 1);
    chk("c_no_hit_outside", hit, 0);

    // Saturating passed counter, then clear and async reset
    do_reset();
    en = 1;
    total = 0;
    exp_pass = 0;
    for (int c = 0; c < 20000 && total < 300; c++) begin
      step();
      if (resp != 4'b0000) begin
        total += $countones(resp);
        exp_pass = (total > 255) ? 255 : total;
        chk("d_passed_track", passed, exp_pass);
      end
    end
    chk("d_300_reached", (total >= 300), 1);
    chk("d_passed_sat", passed, 255);
    clr = 1;
    step();
    clr = 0; en = 0;
    chk_init("clear");
    en = 1;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_init("async_reset");
    #2;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
